csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
Parametrised machine-mode CSR file for the RV32 core, replacing the single-port CSR register block.
- Executes CSRRW/CSRRS/CSRRC semantics internally: write, set bits, clear bits.
- Enforces WARL masks on writable registers and flags illegal accesses.
- Keeps mcycle/minstret counters and synchronised interrupt-pending bits.
- Performs atomic trap-entry and mret updates requested by the interrupt/exception controller.

Parameters:
DATA_W, 32, CSR data width; only 32 is supported.
CYCLE_W, 64, counter width; legal values 32 or 64.
INSTRET_EN, 1, implement minstret; when 0, instret addresses read 0 and writes are ignored without an illegal flag.
VENDOR_ID, 32'h5175616e, value returned for mvendorid.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
ex_op_i  in  2  00 none, 01 write, 10 set, 11 clear
ex_addr_i  in  12  CSR address
ex_data_i  in  DATA_W  operand
ex_data_o  out  DATA_W  pre-update value of ex_addr_i (combinational)
ex_illegal_o  out  1  access illegal (combinational)
retire_i  in  1  one instruction retired this cycle
trap_i  in  1  trap-entry pulse
trap_cause_i  in  DATA_W  mcause value for the trap
trap_pc_i  in  DATA_W  PC to save in mepc
mret_i  in  1  mret-execute pulse
irq_timer_i, irq_ext_i, irq_soft_i  in  1 each  asynchronous interrupt levels
mtvec_o, mepc_o, mstatus_o  out  DATA_W  current register values
global_int_en_o  out  1  mstatus.MIE
irq_pending_o  out  1  MIE & |(mip & mie)

Behaviour:
- Address map:
  - User-level read-only: cycle C00, cycleh C80, instret C02, instreth C82.
  - Machine counters: mcycle B00, mcycleh B80, minstret B02, minstreth B82.
  - Machine registers: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344 (read-only).
  - mvendorid F11 (read-only).
- Reset (rst low, asynchronous):
  - All registers and counters clear to 0.
  - mstatus reads 0x0000_1800 because MPP is hardwired 11.
  - mip clears to 0; all outputs 0 except mstatus_o = 0x1800.
- ex_illegal_o = 1 when op≠00 and either:
  - the address is not in the map, or
  - the address is read-only (C-range, F11, 344).
  - When illegal: no state changes and ex_data_o = 0.
- Write value computation:
  - new = data (write), old|data (set), old&~data (clear).
  - The value is masked, then registered at the next clk edge.
  - ex_data_o always returns the old value; there is no same-cycle forwarding.
- WARL masks:
  - mstatus: writable bits 3 (MIE) and 7 (MPIE); 12:11 read 11; all other bits read 0.
  - mie: writable bits 3, 7, 11 only.
  - mtvec[1:0] and mepc[1:0] read 0.
  - mscratch and mcause: full width.
- mcycle:
  - Increments by 1 every cycle after reset release and wraps from all-ones to 0.
  - A CSR write to either half loads that half; the counter does not increment in that cycle (the other half holds).
- minstret:
  - Increments when retire_i = 1.
  - A CSR write has priority over retire in the same cycle.
- CYCLE_W = 32: the high-half addresses read 0 and writes to them are ignored (not illegal).
- Low-half carry: the high half increments in the same edge as the low half wraps.
- mip:
  - Bits 3/7/11 = irq_soft_i/irq_timer_i/irq_ext_i.
  - Each passes through a 2-flop synchroniser, giving 2-cycle latency from input to mip.
- Trap entry (trap_i = 1), applied at the next edge:
  - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i.
  - MPIE <= MIE; MIE <= 0.
- mret (mret_i = 1): MIE <= MPIE; MPIE <= 1.
- Same-cycle events:
  - trap_i and mret_i together: the trap wins and mret is ignored.
  - trap_i or mret_i together with a CSR write: the CSR write is discarded entirely; ex_illegal_o is still reported.
  - Counters still increment normally during a trap or mret.
- irq_pending_o and global_int_en_o are combinational from registered state only.

Test Plan:
1. Reset, then 10 idle cycles → mcycle reads 10 (±1 for the read edge); mstatus_o = 0x1800; mtvec_o = 0.
2. Write mtvec 0x8000_0007, set mstatus 0xFFFF_FFFF → mtvec reads 0x8000_0004; mstatus reads 0x1888; global_int_en_o = 1.
3. Clear mstatus with 0x8 while reading → ex_data_o = 0x1888 that cycle; next cycle mstatus reads 0x1880.
4. MIE = 1, trap_i with cause 0x8000_0007, pc 0x123 → mepc = 0x120, mcause = 0x8000_0007, MIE = 0, MPIE = 1; then mret_i → MIE = 1, MPIE = 1.
5. Write cycle (C00) or mip, or access address 0x7FF → ex_illegal_o = 1 and no register changes; write mcycle = 0xFFFF_FFFF, next edge → mcycleh increments by 1 and mcycle = 0.
6. mie = 0x80, MIE = 1, assert irq_timer_i → irq_pending_o rises exactly 2 clk later; trap_i and a write to mscratch in the same cycle → mscratch unchanged.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/CSRRS/CSRRC execution with WARL masking, illegal-access
// detection, mcycle/minstret counters, synchronised interrupt pending bits and atomic
// trap-entry / mret updates of mstatus, mepc and mcause.
module csr_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CYCLE_W    = 64,
  parameter bit          INSTRET_EN = 1'b1,
  parameter logic [31:0] VENDOR_ID  = 32'h5175616e
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ex_op_i,
  input  logic [11:0]       ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  output logic [DATA_W-1:0] ex_data_o,
  output logic              ex_illegal_o,
  input  logic              retire_i,
  input  logic              trap_i,
  input  logic [DATA_W-1:0] trap_cause_i,
  input  logic [DATA_W-1:0] trap_pc_i,
  input  logic              mret_i,
  input  logic              irq_timer_i,
  input  logic              irq_ext_i,
  input  logic              irq_soft_i,
  output logic [DATA_W-1:0] mtvec_o,
  output logic [DATA_W-1:0] mepc_o,
  output logic [DATA_W-1:0] mstatus_o,
  output logic              global_int_en_o,
  output logic              irq_pending_o
);

  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  // Architectural state
  logic                mstatus_mie_q, mstatus_mie_d;
  logic                mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]          mie_en_q, mie_en_d;      // {MEIE, MTIE, MSIE}
  logic [31:2]         mtvec_q, mtvec_d;
  logic [31:0]         mscratch_q, mscratch_d;
  logic [31:2]         mepc_q, mepc_d;
  logic [31:0]         mcause_q, mcause_d;
  logic [CYCLE_W-1:0]  mcycle_q, mcycle_d;
  logic [CYCLE_W-1:0]  minstret_q, minstret_d;
  logic [2:0]          irq_s1_q, irq_s1_d;      // {ext, timer, soft}
  logic [2:0]          irq_s2_q, irq_s2_d;

  // Derived views
  logic [31:0] mstatus_val;
  logic [31:0] mie_val;
  logic [31:0] mip_val;
  logic [63:0] cyc_ext;
  logic [63:0] ins_ext;
  logic [63:0] cyc_nxt;
  logic [63:0] ins_nxt;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        addr_valid;
  logic        addr_ro;
  logic        illegal;
  logic        csr_we;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^trap_pc_i[1:0];

  // Register views with hardwired/WARL bits applied
  always_comb begin
    mstatus_val     = 32'h0000_1800;
    mstatus_val[3]  = mstatus_mie_q;
    mstatus_val[7]  = mstatus_mpie_q;
    mie_val         = '0;
    mie_val[3]      = mie_en_q[0];
    mie_val[7]      = mie_en_q[1];
    mie_val[11]     = mie_en_q[2];
    mip_val         = '0;
    mip_val[3]      = irq_s2_q[0];
    mip_val[7]      = irq_s2_q[1];
    mip_val[11]     = irq_s2_q[2];
    cyc_ext         = 64'(mcycle_q);
    ins_ext         = INSTRET_EN ? 64'(minstret_q) : 64'd0;
  end

  // Address decode and read mux; also classifies read-only addresses
  always_comb begin
    rdata      = '0;
    addr_valid = 1'b1;
    addr_ro    = 1'b0;
    case (ex_addr_i)
      12'hC00: begin rdata = cyc_ext[31:0];  addr_ro = 1'b1; end
      12'hC80: begin rdata = cyc_ext[63:32]; addr_ro = 1'b1; end
      12'hC02: begin rdata = ins_ext[31:0];  addr_ro = 1'b1; end
      12'hC82: begin rdata = ins_ext[63:32]; addr_ro = 1'b1; end
      12'hB00: rdata = cyc_ext[31:0];
      12'hB80: rdata = cyc_ext[63:32];
      12'hB02: rdata = ins_ext[31:0];
      12'hB82: rdata = ins_ext[63:32];
      12'h300: rdata = mstatus_val;
      12'h304: rdata = mie_val;
      12'h305: rdata = {mtvec_q, 2'b00};
      12'h340: rdata = mscratch_q;
      12'h341: rdata = {mepc_q, 2'b00};
      12'h342: rdata = mcause_q;
      12'h344: begin rdata = mip_val;   addr_ro = 1'b1; end
      12'hF11: begin rdata = VENDOR_ID; addr_ro = 1'b1; end
      default: addr_valid = 1'b0;
    endcase
  end

  // Legality, CSR write enable and read-modify-write value
  always_comb begin
    illegal = (ex_op_i != OpNone) && (!addr_valid || addr_ro);
    // Trap/mret own the state this cycle; a coincident CSR write is dropped
    csr_we  = (ex_op_i != OpNone) && !illegal && !trap_i && !mret_i;
    case (ex_op_i)
      OpWrite: wdata = ex_data_i;
      OpSet:   wdata = rdata | ex_data_i;
      OpClear: wdata = rdata & ~ex_data_i;
      default: wdata = rdata;
    endcase
  end

  // Counter next values: a CSR write to one half suppresses the increment that cycle
  always_comb begin
    if (csr_we && ex_addr_i == 12'hB00) begin
      cyc_nxt = {cyc_ext[63:32], wdata};
    end else if (csr_we && ex_addr_i == 12'hB80 && CYCLE_W == 64) begin
      cyc_nxt = {wdata, cyc_ext[31:0]};
    end else begin
      cyc_nxt = cyc_ext + 64'd1;
    end
    mcycle_d = cyc_nxt[CYCLE_W-1:0];

    if (csr_we && ex_addr_i == 12'hB02) begin
      ins_nxt = {ins_ext[63:32], wdata};
    end else if (csr_we && ex_addr_i == 12'hB82 && CYCLE_W == 64) begin
      ins_nxt = {wdata, ins_ext[31:0]};
    end else if (retire_i) begin
      ins_nxt = ins_ext + 64'd1;
    end else begin
      ins_nxt = ins_ext;
    end
    minstret_d = INSTRET_EN ? ins_nxt[CYCLE_W-1:0] : '0;
  end

  // Register next values: CSR writes, then trap entry / mret override
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_en_d       = mie_en_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    irq_s1_d       = {irq_ext_i, irq_timer_i, irq_soft_i};
    irq_s2_d       = irq_s1_q;

    if (csr_we) begin
      case (ex_addr_i)
        12'h300: begin
          mstatus_mie_d  = wdata[3];
          mstatus_mpie_d = wdata[7];
        end
        12'h304: mie_en_d   = {wdata[11], wdata[7], wdata[3]};
        12'h305: mtvec_d    = wdata[31:2];
        12'h340: mscratch_d = wdata;
        12'h341: mepc_d     = wdata[31:2];
        12'h342: mcause_d   = wdata;
        default: ;
      endcase
    end

    if (trap_i) begin
      mepc_d         = trap_pc_i[31:2];
      mcause_d       = trap_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_en_q       <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      irq_s1_q       <= '0;
      irq_s2_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_en_q       <= mie_en_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      irq_s1_q       <= irq_s1_d;
      irq_s2_q       <= irq_s2_d;
    end
  end

  // Outputs: read port gated on illegal, status views from registered state only
  always_comb begin
    ex_data_o       = illegal ? '0 : rdata;
    ex_illegal_o    = illegal;
    mtvec_o         = {mtvec_q, 2'b00};
    mepc_o          = {mepc_q, 2'b00};
    mstatus_o       = mstatus_val;
    global_int_en_o = mstatus_mie_q;
    irq_pending_o   = mstatus_mie_q & (|(irq_s2_q & mie_en_q));
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
module tb_csr_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  ex_op_i;
  logic [11:0] ex_addr_i;
  logic [31:0] ex_data_i;
  logic [31:0] ex_data_o;
  logic        ex_illegal_o;
  logic        retire_i;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic        mret_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        irq_soft_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mstatus_o;
  logic        global_int_en_o;
  logic        irq_pending_o;

  int total;
  int bad;
  logic [31:0] v;

  csr_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ex_op_i         (ex_op_i),
    .ex_addr_i       (ex_addr_i),
    .ex_data_i       (ex_data_i),
    .ex_data_o       (ex_data_o),
    .ex_illegal_o    (ex_illegal_o),
    .retire_i        (retire_i),
    .trap_i          (trap_i),
    .trap_cause_i    (trap_cause_i),
    .trap_pc_i       (trap_pc_i),
    .mret_i          (mret_i),
    .irq_timer_i     (irq_timer_i),
    .irq_ext_i       (irq_ext_i),
    .irq_soft_i      (irq_soft_i),
    .mtvec_o         (mtvec_o),
    .mepc_o          (mepc_o),
    .mstatus_o       (mstatus_o),
    .global_int_en_o (global_int_en_o),
    .irq_pending_o   (irq_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and return inputs to idle
  task automatic tick();
    @(negedge clk);
    ex_op_i  = 2'b00;
    trap_i   = 1'b0;
    mret_i   = 1'b0;
    retire_i = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    ex_op_i   = op;
    ex_addr_i = a;
    ex_data_i = d;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] val);
    ex_op_i   = 2'b00;
    ex_addr_i = a;
    #1;
    val = ex_data_o;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ex_op_i = 2'b00; ex_addr_i = '0; ex_data_i = '0;
    retire_i = 1'b0; trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; mret_i = 1'b0;
    irq_timer_i = 1'b0; irq_ext_i = 1'b0; irq_soft_i = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk("rst_mstatus", mstatus_o, 32'h0000_1800);
    chk("rst_mtvec", mtvec_o, 32'h0);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_gie", {31'b0, global_int_en_o}, 32'h0);
    chk("rst_pend", {31'b0, irq_pending_o}, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rd(12'hB00, v); chk("mcycle_after_10", v, 32'd10);
    rd(12'hB80, v); chk("mcycleh_after_10", v, 32'd0);

    // mtvec WARL and mstatus set
    drive(2'b01, 12'h305, 32'h8000_0007); tick();
    chk("mtvec_warl", mtvec_o, 32'h8000_0004);
    drive(2'b10, 12'h300, 32'hFFFF_FFFF); #1;
    chk("mstatus_set_old", ex_data_o, 32'h0000_1800);
    chk("mstatus_set_legal", {31'b0, ex_illegal_o}, 32'h0);
    tick();
    chk("mstatus_set", mstatus_o, 32'h0000_1888);
    chk("gie_set", {31'b0, global_int_en_o}, 32'h1);

    // Clear MIE, read returns pre-update value
    drive(2'b11, 12'h300, 32'h8); #1;
    chk("mstatus_clr_old", ex_data_o, 32'h0000_1888);
    tick();
    chk("mstatus_clr", mstatus_o, 32'h0000_1880);
    chk("gie_clr", {31'b0, global_int_en_o}, 32'h0);

    // Trap entry then mret
    drive(2'b01, 12'h300, 32'h8); tick();
    chk("mstatus_mie_only", mstatus_o, 32'h0000_1808);
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h123;
    tick();
    chk("trap_mepc", mepc_o, 32'h120);
    rd(12'h342, v); chk("trap_mcause", v, 32'h8000_0007);
    chk("trap_mstatus", mstatus_o, 32'h0000_1880);
    mret_i = 1'b1; tick();
    chk("mret_mstatus", mstatus_o, 32'h0000_1888);
    chk("mret_gie", {31'b0, global_int_en_o}, 32'h1);

    // Illegal accesses
    drive(2'b01, 12'hC00, 32'h55); #1;
    chk("ill_cycle", {31'b0, ex_illegal_o}, 32'h1);
    chk("ill_cycle_data", ex_data_o, 32'h0);
    tick();
    drive(2'b01, 12'h344, 32'hFFFF_FFFF); #1;
    chk("ill_mip", {31'b0, ex_illegal_o}, 32'h1);
    tick();
    rd(12'h344, v); chk("mip_unchanged", v, 32'h0);
    drive(2'b10, 12'h7FF, 32'h1); #1;
    chk("ill_unmapped", {31'b0, ex_illegal_o}, 32'h1);
    chk("ill_unmapped_data", ex_data_o, 32'h0);
    tick();
    chk("mtvec_unchanged", mtvec_o, 32'h8000_0004);
    rd(12'hC00, v); chk("read_cycle_legal", {31'b0, ex_illegal_o}, 32'h0);
    rd(12'hF11, v); chk("mvendorid", v, 32'h5175_616e);

    // mcycle load and carry into the high half
    drive(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    rd(12'hB00, v); chk("mcycle_loaded", v, 32'hFFFF_FFFF);
    rd(12'hB80, v); chk("mcycleh_before", v, 32'h0);
    tick();
    rd(12'hB00, v); chk("mcycle_wrap", v, 32'h0);
    rd(12'hB80, v); chk("mcycleh_carry", v, 32'h1);
    drive(2'b01, 12'hB80, 32'h5); tick();
    rd(12'hB80, v); chk("mcycleh_write", v, 32'h5);

    // minstret counting and write priority over retire
    retire_i = 1'b1;
    repeat (3) @(negedge clk);
    retire_i = 1'b0;
    rd(12'hB02, v); chk("minstret_3", v, 32'd3);
    drive(2'b01, 12'hB02, 32'd100); retire_i = 1'b1; tick();
    rd(12'hC02, v); chk("minstret_write_prio", v, 32'd100);

    // mie WARL and synchronised timer interrupt
    drive(2'b01, 12'h304, 32'hFFFF_FFFF); tick();
    rd(12'h304, v); chk("mie_warl", v, 32'h888);
    drive(2'b01, 12'h304, 32'h80); tick();
    chk("pend_idle", {31'b0, irq_pending_o}, 32'h0);
    irq_timer_i = 1'b1;
    tick();
    chk("pend_1clk", {31'b0, irq_pending_o}, 32'h0);
    tick();
    chk("pend_2clk", {31'b0, irq_pending_o}, 32'h1);
    rd(12'h344, v); chk("mip_timer", v, 32'h80);

    // Trap discards a coincident CSR write
    drive(2'b01, 12'h340, 32'hA5A5_A5A5); tick();
    rd(12'h340, v); chk("mscratch_write", v, 32'hA5A5_A5A5);
    drive(2'b01, 12'h340, 32'h1234_5678);
    trap_i = 1'b1; trap_cause_i = 32'hB; trap_pc_i = 32'h200;
    tick();
    rd(12'h340, v); chk("mscratch_trap_drop", v, 32'hA5A5_A5A5);
    rd(12'h342, v); chk("trap2_mcause", v, 32'hB);
    chk("trap2_mepc", mepc_o, 32'h200);
    chk("trap2_gie", {31'b0, global_int_en_o}, 32'h0);
    chk("trap2_pend", {31'b0, irq_pending_o}, 32'h0);

    // Trap wins over a simultaneous mret
    trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h3; trap_pc_i = 32'h301;
    tick();
    chk("trap_mret_mstatus", mstatus_o, 32'h0000_1800);
    chk("trap_mret_mepc", mepc_o, 32'h300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
